// File: rtl/tblink_invoke_arb_pkg.sv
// Shared types and helpers for the tblink invoke-channel arbiter.
package tblink_invoke_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } arb_state_e;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int unsigned tag_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tblink_rr_arbiter.sv
// Combinational round-robin picker: first eligible bit at or after ptr_i, wrapping modulo N.
module tblink_rr_arbiter
    import tblink_invoke_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned W = tag_width(N)
) (
    input  logic [N-1:0] eligible_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] grant_idx_o
);

    logic         found;
    int unsigned  idx;
    logic [W-1:0] sel;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = idx[W-1:0];
            if (!found && eligible_i[sel]) begin
                found        = 1'b1;
                grant_o[sel] = 1'b1;
                grant_idx_o  = sel;
            end
        end
    end

endmodule

// File: rtl/tblink_invoke_arb.sv
// Shares one endpoint invoke channel among NUM_REQ BFM requesters with tagged return routing.
// Define TBLINK_ARB_TIMEOUT_EN to add per-requester call timeouts of TMO_CYC cycles.
module tblink_invoke_arb
    import tblink_invoke_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MID_W   = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TMO_CYC = 1024,
    localparam int unsigned TAG_W  = tag_width(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*MID_W-1:0]  req_mid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      call_valid,
    input  logic                      call_ready,
    output logic [MID_W-1:0]          call_mid,
    output logic [DATA_W-1:0]         call_data,
    output logic [TAG_W-1:0]          call_tag,
    input  logic                      ret_valid,
    input  logic [TAG_W-1:0]          ret_tag,
    input  logic [DATA_W-1:0]         ret_data,
    input  logic                      ret_err,
    output logic [NUM_REQ-1:0]        pending,
    output logic                      err_unexp
);

    // Call record; widths follow the module parameters, so it lives here rather than the package.
    typedef struct packed {
        logic [MID_W-1:0]  mid;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } call_rec_t;

    arb_state_e          state_q, state_d;
    logic [TAG_W-1:0]    ptr_q, ptr_d;
    call_rec_t           call_q, call_d;
    logic [NUM_REQ-1:0]  pending_q, pending_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                err_unexp_q, err_unexp_d;

    logic [NUM_REQ-1:0]  eligible, grant;
    logic [TAG_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0]  ret_onehot;
    logic                ret_hit;
    logic [MID_W-1:0]    mid_arr  [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];

    assign eligible   = req_valid & ~pending_q;
    // Out-of-range tags shift past the top bit and never match a pending requester.
    assign ret_onehot = NUM_REQ'(1) << ret_tag;
    assign ret_hit    = ret_valid && (|(pending_q & ret_onehot));

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            mid_arr[i]  = req_mid[i*MID_W +: MID_W];
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    tblink_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .eligible_i  (eligible),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

`ifdef TBLINK_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TMO_CYC - 1);

    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];
    logic [NUM_REQ-1:0] tmo_fire;
    logic               tmo_found;

    // Expired counters saturate until the shared rsp bus is free; lowest index goes first.
    always_comb begin
        tmo_fire  = '0;
        tmo_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = '0;
            if (pending_q[i]) begin
                cnt_d[i] = (cnt_q[i] == CntMax) ? cnt_q[i] : cnt_q[i] + 1'b1;
            end
            if (pending_q[i] && (cnt_q[i] == CntMax) && !(ret_hit && ret_onehot[i])
                && !ret_hit && !tmo_found) begin
                tmo_fire[i] = 1'b1;
                tmo_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        call_d      = call_q;
        pending_d   = pending_q;
        req_ready   = '0;
        rsp_valid_d = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        err_unexp_d = err_unexp_q;

        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    req_ready   = grant;
                    call_d.mid  = mid_arr[grant_idx];
                    call_d.data = data_arr[grant_idx];
                    call_d.tag  = grant_idx;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (call_ready) begin
                    pending_d[call_q.tag] = 1'b1;
                    ptr_d   = (32'(call_q.tag) == NUM_REQ - 1) ? '0 : call_q.tag + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (ret_valid) begin
            if (ret_hit) begin
                rsp_valid_d = ret_onehot;
                rsp_data_d  = ret_data;
                rsp_err_d   = ret_err;
                pending_d   = pending_d & ~ret_onehot;
            end else begin
                err_unexp_d = 1'b1;
            end
        end

`ifdef TBLINK_ARB_TIMEOUT_EN
        if (|tmo_fire) begin
            rsp_valid_d = tmo_fire;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            pending_d   = pending_d & ~tmo_fire;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            call_q      <= '0;
            pending_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_unexp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            call_q      <= call_d;
            pending_q   <= pending_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            err_unexp_q <= err_unexp_d;
        end
    end

    assign call_valid = (state_q == StIssue);
    assign call_mid   = call_q.mid;
    assign call_data  = call_q.data;
    assign call_tag   = call_q.tag;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign pending    = pending_q;
    assign err_unexp  = err_unexp_q;

endmodule
